// File: rtl/prio_enc_pkg.sv
// Shared constants, buffer state type and width helper for the priority encoder.
package prio_enc_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

    // Index width for n lines, never below 1 so that n=2 still gets a 1-bit index.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/prio_encoder_rr_scan.sv
// Combinational circular search: first set bit starting at 'start', walking up
// (or down when DESCEND=1) and wrapping modulo N.
module prio_scan
    import prio_enc_pkg::*;
#(
    parameter int N       = 8,
    parameter bit DESCEND = 1'b0,
    localparam int W      = clog2_min1(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         found,
    output logic         multi
);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            int p;
            p = DESCEND ? (int'(start) - k) : (int'(start) + k);
            // start <= N-1 and k <= N-1, so one correction keeps p within 0..N-1
            if (p < 0) begin
                p = p + N;
            end else if (p >= N) begin
                p = p - N;
            end
            if (!found && vec[p]) begin
                found = 1'b1;
                idx   = W'(p);
            end
        end
    end

    assign multi = ($countones(vec) > 1);

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered N-to-log2(N) priority encoder with a one-entry output buffer and
// valid/ready on both sides; fixed highest-index priority or round-robin.
module prio_encoder_rr
    import prio_enc_pkg::*;
#(
    parameter int  N    = 8,
    parameter int  MODE = MODE_FIXED,
    localparam int W    = clog2_min1(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [N-1:0] req,
    output logic         enc_valid,
    input  logic         enc_ready,
    output logic [W-1:0] enc_idx,
    output logic         enc_zero,
    output logic         enc_multi,
    output logic [W-1:0] rr_ptr
);

    localparam logic [W-1:0] LAST_IDX = W'(N - 1);
    localparam bit           IS_RR    = (MODE == MODE_RR);

    buf_state_e   state_q, state_d;
    logic [W-1:0] enc_idx_q, enc_idx_d;
    logic         enc_zero_q, enc_zero_d;
    logic         enc_multi_q, enc_multi_d;
    logic [W-1:0] rr_ptr_q, rr_ptr_d;

    logic [W-1:0] scan_start;
    logic [W-1:0] scan_idx;
    logic         scan_found;
    logic         scan_multi;
    logic         in_xfer;

    // Fixed priority is a descending search that always starts at the top line.
    assign scan_start = IS_RR ? rr_ptr_q : LAST_IDX;

    prio_scan #(
        .N       (N),
        .DESCEND (!IS_RR)
    ) u_scan (
        .vec   (req),
        .start (scan_start),
        .idx   (scan_idx),
        .found (scan_found),
        .multi (scan_multi)
    );

    assign enc_valid = (state_q == BUF_FULL);
    assign req_ready = !enc_valid || enc_ready;
    assign in_xfer   = req_valid && req_ready;

    always_comb begin
        state_d     = state_q;
        enc_idx_d   = enc_idx_q;
        enc_zero_d  = enc_zero_q;
        enc_multi_d = enc_multi_q;
        rr_ptr_d    = rr_ptr_q;
        if (in_xfer) begin
            state_d     = BUF_FULL;
            enc_idx_d   = scan_found ? scan_idx : '0;
            enc_zero_d  = !scan_found;
            enc_multi_d = scan_multi;
            if (IS_RR && scan_found) begin
                rr_ptr_d = (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
            end
        end else if (enc_ready) begin
            state_d = BUF_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= BUF_EMPTY;
            enc_idx_q   <= '0;
            enc_zero_q  <= 1'b0;
            enc_multi_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            enc_idx_q   <= enc_idx_d;
            enc_zero_q  <= enc_zero_d;
            enc_multi_q <= enc_multi_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign enc_idx   = enc_idx_q;
    assign enc_zero  = enc_zero_q;
    assign enc_multi = enc_multi_q;
    assign rr_ptr    = rr_ptr_q;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Three encoder instances (fixed N=8, round-robin N=8, round-robin N=5) driven by
// directed and random stimulus; a per-instance scoreboard checks every output transfer.
module tb_prio_encoder_rr;

    typedef struct {
        int idx;
        bit zero;
        bit multi;
        int ptr;
    } exp_t;

    logic            clk;
    logic            rst;
    logic [2:0]      req_valid_s;
    logic [2:0]      req_ready_s;
    logic [2:0][7:0] req_s;
    logic [2:0]      enc_valid_s;
    logic [2:0]      enc_ready_s;
    logic [2:0][2:0] idx_s;
    logic [2:0]      zero_s;
    logic [2:0]      multi_s;
    logic [2:0][2:0] ptr_s;
    bit              mon_en;

    int errors;
    int checks;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    prio_encoder_rr #(.N(8), .MODE(0)) u_fix8 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_s[0]), .req_ready(req_ready_s[0]), .req(req_s[0]),
        .enc_valid(enc_valid_s[0]), .enc_ready(enc_ready_s[0]), .enc_idx(idx_s[0]),
        .enc_zero(zero_s[0]), .enc_multi(multi_s[0]), .rr_ptr(ptr_s[0])
    );

    prio_encoder_rr #(.N(8), .MODE(1)) u_rr8 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_s[1]), .req_ready(req_ready_s[1]), .req(req_s[1]),
        .enc_valid(enc_valid_s[1]), .enc_ready(enc_ready_s[1]), .enc_idx(idx_s[1]),
        .enc_zero(zero_s[1]), .enc_multi(multi_s[1]), .rr_ptr(ptr_s[1])
    );

    prio_encoder_rr #(.N(5), .MODE(1)) u_rr5 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_s[2]), .req_ready(req_ready_s[2]), .req(req_s[2][4:0]),
        .enc_valid(enc_valid_s[2]), .enc_ready(enc_ready_s[2]), .enc_idx(idx_s[2]),
        .enc_zero(zero_s[2]), .enc_multi(multi_s[2]), .rr_ptr(ptr_s[2])
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int dut_n(input int i);
        return (i == 2) ? 5 : 8;
    endfunction

    function automatic int dut_mode(input int i);
        return (i == 0) ? 0 : 1;
    endfunction

    // Reference: count the set lines, then pick the winner by a plain walk over the
    // line numbers; the pointer advances past the winner in round-robin mode.
    function automatic exp_t ref_encode(input int n, input int mode, input logic [7:0] v,
                                        input int ptr_in);
        exp_t e;
        int   cnt;
        cnt     = 0;
        e.idx   = 0;
        e.ptr   = ptr_in;
        for (int i = 0; i < n; i++) begin
            if (v[i]) cnt++;
        end
        e.zero  = (cnt == 0);
        e.multi = (cnt >= 2);
        if (cnt != 0) begin
            if (mode == 0) begin
                for (int i = 0; i < n; i++) begin
                    if (v[i]) e.idx = i;
                end
            end else begin
                for (int k = n - 1; k >= 0; k--) begin
                    if (v[(ptr_in + k) % n]) e.idx = (ptr_in + k) % n;
                end
                e.ptr = (e.idx + 1) % n;
            end
        end
        return e;
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_mon
        exp_t q[$];
        int   mptr = 0;
        int   n_out = 0;

        always @(negedge clk) begin
            if (mon_en) begin
                if (rst) begin
                    q.delete();
                    mptr = 0;
                end else begin
                    exp_t e;
                    check($sformatf("d%0d_valid_vs_pending", gi),
                          int'(enc_valid_s[gi]), int'(q.size() != 0));
                    check($sformatf("d%0d_req_ready", gi), int'(req_ready_s[gi]),
                          int'(!enc_valid_s[gi] || enc_ready_s[gi]));
                    check($sformatf("d%0d_ptr_range", gi),
                          int'(int'(ptr_s[gi]) < dut_n(gi)), 1);
                    if (enc_valid_s[gi] && enc_ready_s[gi] && q.size() != 0) begin
                        e = q.pop_front();
                        n_out++;
                        check($sformatf("d%0d_idx", gi), int'(idx_s[gi]), e.idx);
                        check($sformatf("d%0d_zero", gi), int'(zero_s[gi]), int'(e.zero));
                        check($sformatf("d%0d_multi", gi), int'(multi_s[gi]), int'(e.multi));
                        check($sformatf("d%0d_rr_ptr", gi), int'(ptr_s[gi]), e.ptr);
                    end
                    if (req_valid_s[gi] && req_ready_s[gi]) begin
                        e = ref_encode(dut_n(gi), dut_mode(gi), req_s[gi], mptr);
                        mptr = e.ptr;
                        q.push_back(e);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam int RR5_LEN = 5;
    logic [7:0] rr5_vec  [RR5_LEN] = '{8'h11, 8'h00, 8'h11, 8'h11, 8'h11};
    int         rr5_idx  [RR5_LEN] = '{0, 0, 4, 0, 4};
    int         rr5_zero [RR5_LEN] = '{0, 1, 0, 0, 0};
    int         rr5_ptr  [RR5_LEN] = '{1, 1, 0, 1, 0};

    initial begin
        errors      = 0;
        checks      = 0;
        mon_en      = 1'b0;
        rst         = 1'b1;
        req_valid_s = '0;
        req_s       = '0;
        enc_ready_s = '1;
        repeat (2) tick();
        rst    = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_valid%0d", i), int'(enc_valid_s[i]), 0);
            check($sformatf("rst_idx%0d", i), int'(idx_s[i]), 0);
            check($sformatf("rst_zero%0d", i), int'(zero_s[i]), 0);
            check($sformatf("rst_multi%0d", i), int'(multi_s[i]), 0);
            check($sformatf("rst_ptr%0d", i), int'(ptr_s[i]), 0);
            check($sformatf("rst_req_ready%0d", i), int'(req_ready_s[i]), 1);
        end

        // Fixed priority: two-hot vector, then all zeros
        req_s[0] = 8'h48; req_valid_s[0] = 1'b1;
        tick();
        req_valid_s[0] = 1'b0;
        check("fix_valid", int'(enc_valid_s[0]), 1);
        check("fix_idx", int'(idx_s[0]), 6);
        check("fix_multi", int'(multi_s[0]), 1);
        check("fix_zero", int'(zero_s[0]), 0);
        req_s[0] = 8'h00; req_valid_s[0] = 1'b1;
        tick();
        req_valid_s[0] = 1'b0;
        check("zero_valid", int'(enc_valid_s[0]), 1);
        check("zero_flag", int'(zero_s[0]), 1);
        check("zero_idx", int'(idx_s[0]), 0);
        check("zero_multi", int'(multi_s[0]), 0);
        tick();

        // Backpressure: result held, second request refused until downstream ready
        enc_ready_s[0] = 1'b0;
        req_s[0] = 8'h01; req_valid_s[0] = 1'b1;
        tick();
        req_s[0] = 8'h80;
        check("bp_first_idx", int'(idx_s[0]), 0);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_req_ready", int'(req_ready_s[0]), 0);
            check("bp_idx_hold", int'(idx_s[0]), 0);
            check("bp_valid_hold", int'(enc_valid_s[0]), 1);
        end
        enc_ready_s[0] = 1'b1;
        tick();
        req_valid_s[0] = 1'b0;
        check("bp_next_idx", int'(idx_s[0]), 7);
        tick();

        // Round-robin fairness over all-ones
        req_s[1] = 8'hFF; req_valid_s[1] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("rr8_idx", int'(idx_s[1]), k % 8);
            check("rr8_ptr", int'(ptr_s[1]), (k + 1) % 8);
            check("rr8_multi", int'(multi_s[1]), 1);
        end
        req_valid_s[1] = 1'b0;
        tick();

        // Reset during a stall with the pointer at 3
        enc_ready_s[1] = 1'b0;
        req_s[1] = 8'h04; req_valid_s[1] = 1'b1;
        tick();
        req_valid_s[1] = 1'b0;
        check("stall_idx", int'(idx_s[1]), 2);
        check("stall_ptr", int'(ptr_s[1]), 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", int'(enc_valid_s[1]), 0);
        check("midrst_ptr", int'(ptr_s[1]), 0);
        enc_ready_s[1] = 1'b1;
        req_s[1] = 8'h08; req_valid_s[1] = 1'b1;
        tick();
        req_valid_s[1] = 1'b0;
        check("midrst_idx", int'(idx_s[1]), 3);
        tick();

        // Round-robin with N=5, including a zero vector mid-sequence
        req_valid_s[2] = 1'b1;
        for (int k = 0; k < RR5_LEN; k++) begin
            req_s[2] = rr5_vec[k];
            tick();
            check("rr5_idx", int'(idx_s[2]), rr5_idx[k]);
            check("rr5_zero", int'(zero_s[2]), rr5_zero[k]);
            check("rr5_ptr", int'(ptr_s[2]), rr5_ptr[k]);
        end
        req_valid_s[2] = 1'b0;
        tick();

        // Random traffic on all instances; the scoreboards do the checking
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++) begin
                req_valid_s[i] = ($urandom_range(0, 9) < 7);
                enc_ready_s[i] = ($urandom_range(0, 9) < 6);
                req_s[i]       = 8'($urandom_range(0, (i == 2) ? 31 : 255));
                if ($urandom_range(0, 7) == 0) req_s[i] = 8'h00;
            end
            tick();
        end

        req_valid_s = '0;
        enc_ready_s = '1;
        repeat (3) tick();
        check("drain_q0", g_mon[0].q.size(), 0);
        check("drain_q1", g_mon[1].q.size(), 0);
        check("drain_q2", g_mon[2].q.size(), 0);
        check("outputs_seen0", int'(g_mon[0].n_out > 50), 1);
        check("outputs_seen1", int'(g_mon[1].n_out > 50), 1);
        check("outputs_seen2", int'(g_mon[2].n_out > 50), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prio_encoder_rr.md
Name: prio_encoder_rr

Overview:
- Parametrised, registered N-to-log2(N) encoder with valid/ready handshakes on input and output.
- Two modes:
  - fixed priority: highest set bit wins.
  - round-robin: rotating start pointer, so no request line starves.
- Flags an all-zero input and multi-hot inputs rather than driving an undefined code.
- Sits between request-collection logic and downstream grant/decode logic in the datapath.

Parameters:
- N, 8, number of request lines; legal range 2..64.
- MODE, 0, 0 = fixed priority (highest index wins), 1 = round-robin.
- W, $clog2(N), index width; localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  input request vector valid.
- req_ready  out  1  block can accept req this cycle.
- req  in  N  request vector; bit i = line i requesting.
- enc_valid  out  1  encoded result valid.
- enc_ready  in  1  downstream accepts result.
- enc_idx  out  W  selected line index (binary, bit position).
- enc_zero  out  1  captured vector was all zeros; enc_idx = 0.
- enc_multi  out  1  captured vector had more than one bit set.
- rr_ptr  out  W  current round-robin start pointer (debug/verification); held at 0 in MODE 0.

Behaviour:
- All state updates on the rising edge of clk. rst is sampled synchronously and has priority over every other event.
- Reset values: enc_valid=0, enc_idx=0, enc_zero=0, enc_multi=0, rr_ptr=0. req_ready=1 in the cycle after reset deasserts.
- Output register is a single-entry buffer with two states:
  - EMPTY (enc_valid=0)
  - FULL (enc_valid=1)
- req_ready = !enc_valid || enc_ready (combinational). Full-throughput pass-through: one result per cycle when downstream is always ready.
- Input transfer: req_valid && req_ready. On transfer, the result registers load next cycle and enc_valid=1. Latency is exactly 1 clock from input handshake to enc_valid.
- Output transfer: enc_valid && enc_ready.
  - Without a simultaneous input transfer: enc_valid goes to 0 next cycle.
  - With a simultaneous input transfer: the new result replaces the old and enc_valid stays 1.
- While FULL and enc_ready=0:
  - req_ready=0.
  - enc_idx, enc_zero and enc_multi hold stable.
  - req is ignored.
- MODE 0: enc_idx = highest i with req[i]=1.
- MODE 1: search i = rr_ptr, rr_ptr+1, ..., wrapping modulo N. enc_idx = first set bit found.
- rr_ptr update (MODE 1 only): on an input transfer with a nonzero vector, rr_ptr <= enc_idx_next + 1 modulo N (N-1 wraps to 0). A zero vector leaves rr_ptr unchanged.
- Zero vector: enc_zero=1, enc_idx=0, enc_multi=0. The transfer still completes and produces a result.
- enc_multi=1 iff popcount(req) >= 2; evaluated in both modes.
- Non-power-of-two N: rr_ptr and enc_idx never exceed N-1. The wrap compare is against N-1, not 2^W-1.
- Reset mid-operation: a pending result is discarded, enc_valid=0 and rr_ptr=0 next cycle. No output handshake occurs in the reset cycle.

Decomposition:
- Shared package prio_enc_pkg holds:
  - localparam MODE_FIXED=0, MODE_RR=1.
  - A function clog2_min1, returning at least 1 so N=2 gives W=1.
- One natural sub-module: prio_scan.
  - Combinational, parametrised by N.
  - Inputs: vector and start pointer. Outputs: index, found, multi.
  - MODE 0 drives the start pointer as a reversed-order constant; MODE 1 drives rr_ptr.
  - The top level holds only the handshake register and the pointer.

Test Plan:
- Reset/basic (MODE 0, N=8):
  - Hold rst 2 cycles, then check all outputs are 0 and req_ready=1.
  - Send req=8'b0100_1000 with enc_ready=1: one cycle later enc_valid=1, enc_idx=6, enc_multi=1, enc_zero=0.
- Zero input (MODE 0): send req=0 -> enc_valid=1, enc_zero=1, enc_idx=0, enc_multi=0.
- Backpressure: enc_ready=0 after the first result from req=8'h01.
  - req_ready=0 and enc_idx=0 holds for 5 cycles.
  - A second req=8'h80 presented during the stall is not accepted.
  - After raising enc_ready, the next result is enc_idx=7.
- Round-robin fairness (MODE 1, N=8): hold req=8'hFF with both valids high for 10 cycles -> enc_idx sequence 0,1,...,7,0,1; rr_ptr wraps 7->0.
- Round-robin, non-power-of-two (MODE 1, N=5):
  - req=5'b10001 repeatedly -> enc_idx 0,4,0,4.
  - rr_ptr never reaches 5..7.
  - A zero vector mid-sequence leaves rr_ptr unchanged.
- Reset mid-stall (MODE 1): with FULL, enc_ready=0 and rr_ptr=3, pulse rst for 1 cycle -> next cycle enc_valid=0, rr_ptr=0; req=8'h08 then gives enc_idx=3.
